uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_fifo_mem.sv | 84 ++++++++
 rtl/uart_tx_fifo.sv | 122 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART transmit FIFO: data width default
// and the drain state machine encoding.
package uart_pkg;

    localparam int DATA_W_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SEND      = 2'd1,
        WAIT_DONE = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_fifo_mem.sv
// Circular-buffer storage for the UART transmit FIFO: array, read/write
// pointers and occupancy count. Pushes into a full buffer are dropped.
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_req,
    input  logic [DATA_W-1:0]          push_data,
    input  logic                       pop_req,
    output logic [DATA_W-1:0]          pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_d;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              push_s;
    logic              pop_s;

    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == CNT_W'(0));
    assign count    = count_q;
    assign pop_data = mem_q[rd_ptr_q];

    // Qualify requests against occupancy and compute next pointers/count
    always_comb begin
        push_s = push_req & ~full;
        pop_s  = pop_req & ~empty;

        if (push_s) begin
            wr_ptr_d = (wr_ptr_q == PTR_LAST) ? PTR_W'(0) : wr_ptr_q + PTR_W'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = (rd_ptr_q == PTR_LAST) ? PTR_W'(0) : rd_ptr_q + PTR_W'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= PTR_W'(0);
            rd_ptr_q <= PTR_W'(0);
            count_q  <= CNT_W'(0);
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents need no reset since count gates every read
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit FIFO with drain FSM handing one byte at a time to the UART.
// Define UART_TX_FIFO_OVERFLOW_EN to build the sticky overflow flag.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       enable_tx,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_done,
    output logic                       overflow
);

    tx_state_e         state_q;
    tx_state_e         state_d;
    logic              enable_tx_q;
    logic              enable_tx_d;
    logic [DATA_W-1:0] tx_data_q;
    logic [DATA_W-1:0] tx_data_d;
    logic              pop_s;
    logic [DATA_W-1:0] head_s;

    uart_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_mem (
        .clk       (clk),
        .rst       (rst),
        .push_req  (wr_en),
        .push_data (wr_data),
        .pop_req   (pop_s),
        .pop_data  (head_s),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Drain FSM: the head is popped and latched on the same edge that enters SEND
    always_comb begin
        state_d     = state_q;
        enable_tx_d = 1'b0;
        tx_data_d   = tx_data_q;
        pop_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop_s       = 1'b1;
                    tx_data_d   = head_s;
                    enable_tx_d = 1'b1;
                    state_d     = SEND;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (tx_done) begin
                    state_d = IDLE;
                end else begin
                    state_d = WAIT_DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered UART-side outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            enable_tx_q <= 1'b0;
            tx_data_q   <= DATA_W'(0);
        end else begin
            state_q     <= state_d;
            enable_tx_q <= enable_tx_d;
            tx_data_q   <= tx_data_d;
        end
    end

    assign enable_tx = enable_tx_q;
    assign tx_data   = tx_data_q;

`ifdef UART_TX_FIFO_OVERFLOW_EN
    logic overflow_q;
    logic overflow_d;

    // Sticky flag set by any write attempted while full
    always_comb begin
        if (wr_en && full) begin
            overflow_d = 1'b1;
        end else begin
            overflow_d = overflow_q;
        end
    end

    // Overflow register, cleared only by reset
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign overflow = overflow_q;
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: directed scenarios plus randomized
// traffic compared against a queue-based transaction model.
module tb_uart_tx_fifo;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef UART_TX_FIFO_OVERFLOW_EN
    localparam bit OVF_EN = 1'b1;
`else
    localparam bit OVF_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             enable_tx;
    logic [7:0]       tx_data;
    logic             tx_done;
    logic             overflow;

    always #5 clk = ~clk;

    uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_en     (wr_en),
        .wr_data   (wr_data),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .enable_tx (enable_tx),
        .tx_data   (tx_data),
        .tx_done   (tx_done),
        .overflow  (overflow)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // every start pulse seen on the UART side, with its cycle number
    logic [7:0] seen_data[$];
    int         seen_cyc[$];
    always @(negedge clk) begin
        if (enable_tx === 1'b1) begin
            seen_data.push_back(tx_data);
            seen_cyc.push_back(cyc);
        end
    end

    // transaction model: bytes waiting, whether the UART owns a byte, pulse
    logic [7:0] m_q[$];
    bit         m_busy = 1'b0;
    bit         m_en = 1'b0;
    bit         m_ovf = 1'b0;
    logic [7:0] m_tx = 8'h00;

    task automatic tick(input bit r, input bit wr, input logic [7:0] d, input bit done);
        bit was_full;
        bit was_empty;
        bit take;
        bit ack;
        rst = r; wr_en = wr; wr_data = d; tx_done = done;
        if (r) begin
            m_q.delete(); m_busy = 1'b0; m_en = 1'b0; m_ovf = 1'b0; m_tx = 8'h00;
        end else begin
            was_full  = (m_q.size() == DEPTH);
            was_empty = (m_q.size() == 0);
            ack  = done && m_busy && !m_en;
            take = !m_busy && !was_empty;
            if (take) m_tx = m_q.pop_front();
            if (wr && !was_full) m_q.push_back(d);
            if (wr && was_full && OVF_EN) m_ovf = 1'b1;
            m_busy = take || (m_busy && !ack);
            m_en = take;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 1'b1, 8'(8'h30 + i), 1'b0);
        tick(1'b1, 1'b1, 8'hEE, 1'b0);
        checks += 6;
        if (count !== 5'd0) begin errors++; $display("FAIL rst_count got %0d want 0", count); end
        if (empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b want 1", empty); end
        if (full !== 1'b0) begin errors++; $display("FAIL rst_full got %b want 0", full); end
        if (enable_tx !== 1'b0) begin errors++; $display("FAIL rst_enable got %b want 0", enable_tx); end
        if (tx_data !== 8'h00) begin errors++; $display("FAIL rst_txdata got %h want 00", tx_data); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", overflow); end
    endtask

    task automatic test_single();
        int base;
        int wc;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        base = seen_data.size();
        wc = cyc;
        tick(1'b0, 1'b1, 8'h41, 1'b0);
        repeat (20) tick(1'b0, 1'b0, 8'h00, 1'b0);
        checks += 3;
        if (seen_data.size() != base + 1) begin
            errors++; $display("FAIL single_pulses got %0d want 1", seen_data.size() - base);
        end else begin
            if (seen_data[base] !== 8'h41) begin errors++; $display("FAIL single_data got %h want 41", seen_data[base]); end
            if (seen_cyc[base] != wc + 2) begin errors++; $display("FAIL single_latency got %0d want %0d", seen_cyc[base], wc + 2); end
        end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        checks += 3;
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL single_idle got %0d want %0d", dut.state_q, IDLE); end
        if (empty !== 1'b1) begin errors++; $display("FAIL single_empty got %b want 1", empty); end
        if (seen_data.size() != base + 1) begin errors++; $display("FAIL single_extra got %0d want 1", seen_data.size() - base); end
    endtask

    task automatic test_fill();
        int base;
        int n;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        base = seen_data.size();
        for (int i = 1; i <= 16; i++) tick(1'b0, 1'b1, 8'(i), 1'b0);
        checks += 2;
        if (count !== 5'd15) begin errors++; $display("FAIL fill_count15 got %0d want 15", count); end
        if (full !== 1'b0) begin errors++; $display("FAIL fill_notfull got %b want 0", full); end
        tick(1'b0, 1'b1, 8'h11, 1'b0);
        checks += 3;
        if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b want 1", full); end
        if (count !== 5'd16) begin errors++; $display("FAIL fill_count16 got %0d want 16", count); end
        if (overflow !== 1'b0) begin errors++; $display("FAIL fill_noovf got %b want 0", overflow); end
        tick(1'b0, 1'b1, 8'h12, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b0);
        checks += 2;
        if (count !== 5'd16) begin errors++; $display("FAIL fill_drop got %0d want 16", count); end
        if (overflow !== OVF_EN) begin errors++; $display("FAIL fill_ovf got %b want %b", overflow, OVF_EN); end
        n = 0;
        while (seen_data.size() < base + 17 && n < 200) begin tick(1'b0, 1'b0, 8'h00, 1'b1); n++; end
        repeat (8) tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks += 2;
        if (overflow !== OVF_EN) begin errors++; $display("FAIL fill_ovf_sticky got %b want %b", overflow, OVF_EN); end
        if (seen_data.size() != base + 17) begin
            errors++; $display("FAIL fill_drain_count got %0d want 17", seen_data.size() - base);
        end else begin
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (seen_data[base + i] !== 8'(i + 1)) begin
                    errors++; $display("FAIL fill_order[%0d] got %h want %h", i, seen_data[base + i], 8'(i + 1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        int n;
        int done_cyc;
        logic [7:0] exp_b;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        base = seen_data.size();
        done_cyc = 0;
        tick(1'b0, 1'b1, 8'hA0, 1'b0);
        tick(1'b0, 1'b1, 8'hA1, 1'b0);
        tick(1'b0, 1'b1, 8'hA2, 1'b0);
        for (int i = 0; i < 3; i++) begin
            n = 0;
            while (seen_data.size() < base + i + 1 && n < 50) begin tick(1'b0, 1'b0, 8'h00, 1'b0); n++; end
            checks++;
            if (seen_data.size() < base + i + 1) begin
                errors++; $display("FAIL b2b_timeout[%0d] got %0d pulses want %0d", i, seen_data.size() - base, i + 1);
            end else begin
                exp_b = 8'(8'hA0 + i);
                if (seen_data[base + i] !== exp_b) begin
                    errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, seen_data[base + i], exp_b);
                end
                if (i > 0) begin
                    checks++;
                    if (seen_cyc[base + i] != done_cyc + 2) begin
                        errors++; $display("FAIL b2b_gap[%0d] got %0d want %0d", i, seen_cyc[base + i], done_cyc + 2);
                    end
                end
            end
            repeat (3) tick(1'b0, 1'b0, 8'h00, 1'b0);
            done_cyc = cyc;
            tick(1'b0, 1'b0, 8'h00, 1'b1);
        end
        repeat (6) tick(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (seen_data.size() != base + 3) begin errors++; $display("FAIL b2b_total got %0d want 3", seen_data.size() - base); end
    endtask

    task automatic test_wrap();
        int base;
        int n;
        int written;
        logic [7:0] d;
        logic [7:0] exp_q[$];
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        base = seen_data.size();
        for (int i = 0; i < 6; i++) begin d = 8'($urandom); exp_q.push_back(d); tick(1'b0, 1'b1, d, 1'b0); end
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        checks++;
        if (count !== 5'd5) begin errors++; $display("FAIL wrap_pre_count got %0d want 5", count); end
        d = 8'($urandom); exp_q.push_back(d);
        tick(1'b0, 1'b1, d, 1'b0);
        checks++;
        if (count !== 5'd5) begin errors++; $display("FAIL wrap_pushpop_count got %0d want 5", count); end
        written = 0;
        n = 0;
        while (written < 40 && n < 2000) begin
            if (m_q.size() < DEPTH) begin
                d = 8'($urandom); exp_q.push_back(d); written++;
                tick(1'b0, 1'b1, d, 1'b1);
            end else begin
                tick(1'b0, 1'b0, 8'h00, 1'b1);
            end
            n++;
        end
        n = 0;
        while (seen_data.size() < base + exp_q.size() && n < 500) begin tick(1'b0, 1'b0, 8'h00, 1'b1); n++; end
        checks++;
        if (seen_data.size() != base + exp_q.size()) begin
            errors++; $display("FAIL wrap_count got %0d want %0d", seen_data.size() - base, exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (seen_data[base + i] !== exp_q[i]) begin
                    errors++; $display("FAIL wrap_order[%0d] got %h want %h", i, seen_data[base + i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        int base;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
        checks += 2;
        if (count !== 5'd4) begin errors++; $display("FAIL rmid_count4 got %0d want 4", count); end
        if (dut.state_q !== WAIT_DONE) begin errors++; $display("FAIL rmid_wait got %0d want %0d", dut.state_q, WAIT_DONE); end
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        base = seen_data.size();
        checks += 4;
        if (count !== 5'd0) begin errors++; $display("FAIL rmid_count got %0d want 0", count); end
        if (enable_tx !== 1'b0) begin errors++; $display("FAIL rmid_enable got %b want 0", enable_tx); end
        if (empty !== 1'b1) begin errors++; $display("FAIL rmid_empty got %b want 1", empty); end
        if (dut.state_q !== IDLE) begin errors++; $display("FAIL rmid_idle got %0d want %0d", dut.state_q, IDLE); end
        repeat (2) tick(1'b0, 1'b0, 8'h00, 1'b0);
        tick(1'b0, 1'b0, 8'h00, 1'b1);
        repeat (6) tick(1'b0, 1'b0, 8'h00, 1'b0);
        checks++;
        if (seen_data.size() != base) begin errors++; $display("FAIL rmid_stray got %0d pulses want 0", seen_data.size() - base); end
    endtask

    task automatic test_random();
        bit r;
        bit wr;
        bit dn;
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 79) == 0);
            wr = (i < 300) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
            dn = ($urandom_range(0, 2) == 0);
            tick(r, wr, 8'($urandom), dn);
            checks += 6;
            if (count !== CNT_W'(m_q.size())) begin errors++; $display("FAIL rnd_count cyc=%0d got %0d want %0d", cyc, count, m_q.size()); end
            if (empty !== (m_q.size() == 0)) begin errors++; $display("FAIL rnd_empty cyc=%0d got %b want %b", cyc, empty, m_q.size() == 0); end
            if (full !== (m_q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full cyc=%0d got %b want %b", cyc, full, m_q.size() == DEPTH); end
            if (enable_tx !== m_en) begin errors++; $display("FAIL rnd_enable cyc=%0d got %b want %b", cyc, enable_tx, m_en); end
            if (tx_data !== m_tx) begin errors++; $display("FAIL rnd_txdata cyc=%0d got %h want %h", cyc, tx_data, m_tx); end
            if (overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf cyc=%0d got %b want %b", cyc, overflow, m_ovf); end
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; tx_done = 1'b0;
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_wrap();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
